// File: rtl/bus_pkg.sv
// Shared types and widths for the 20-bit local bus and its target responder.
package bus_pkg;

    localparam int unsigned BUS_ADDR_W = 20;
    localparam int unsigned BUS_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } resp_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } bus_op_t;

endpackage

// File: rtl/resp_storage.sv
// Byte-wide storage array: synchronous write port, combinational read port.
module resp_storage
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [BUS_DATA_W-1:0] wdata,
    output logic [BUS_DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    logic [BUS_DATA_W-1:0] mem [DEPTH];

    // Contents are intentionally left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/bus_target_responder.sv
// Memory-mapped bus target: window decode, programmable wait states and one
// storage access per strobe assertion, completed with a one-cycle ready pulse.
module bus_target_responder
    import bus_pkg::*;
#(
    parameter logic [BUS_ADDR_W-1:0] BASE_ADDR   = 20'h00000,
    parameter int unsigned           ADDR_BITS   = 8,
    parameter int unsigned           WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ale,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [BUS_ADDR_W-1:0] addr_bus,
    input  logic [BUS_DATA_W-1:0] data_in,
    output logic [BUS_DATA_W-1:0] data_out,
    output logic                  ready,
    output logic                  busy,
    output logic                  sel
);

    localparam int unsigned     WCNT_W    = 4;
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_STATES);

    resp_state_t           state, state_nx;
    bus_op_t               op, op_nx;
    logic [WCNT_W-1:0]     wcnt, wcnt_nx;
    logic [ADDR_BITS-1:0]  offset, offset_nx;
    logic [BUS_DATA_W-1:0] data_out_nx;
    logic [BUS_DATA_W-1:0] mem_rdata;
    logic                  ready_nx, busy_nx, sel_nx;
    logic                  mem_we;
    logic [BUS_ADDR_W-1:0] diff;
    logic                  hit;
    logic                  strobe;

    // Wrap-around subtraction makes addresses below BASE_ADDR land far outside the window.
    assign diff   = addr_bus - BASE_ADDR;
    assign hit    = (diff >> ADDR_BITS) == '0;
    assign strobe = rd | wr;

    resp_storage #(
        .ADDR_BITS (ADDR_BITS)
    ) u_storage (
        .clk   (clk),
        .we    (mem_we),
        .addr  (offset),
        .wdata (data_in),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_nx    = state;
        op_nx       = op;
        wcnt_nx     = wcnt;
        offset_nx   = offset;
        sel_nx      = sel;
        ready_nx    = 1'b0;
        data_out_nx = data_out;
        mem_we      = 1'b0;

        case (state)
            IDLE: begin
                if (ale && strobe && hit) begin
                    offset_nx = diff[ADDR_BITS-1:0];
                    op_nx     = rd ? OP_RD : OP_WR;
                    sel_nx    = 1'b1;
                    wcnt_nx   = WAIT_INIT;
                    state_nx  = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                // A dropped strobe abandons the transaction before any access.
                if (!strobe) begin
                    state_nx = IDLE;
                    sel_nx   = 1'b0;
                    wcnt_nx  = '0;
                end else begin
                    wcnt_nx = wcnt - WCNT_W'(1);
                    if (wcnt == WCNT_W'(1)) begin
                        state_nx = ACCESS;
                    end
                end
            end
            ACCESS: begin
                ready_nx = 1'b1;
                state_nx = DONE;
                if (op == OP_RD) begin
                    data_out_nx = mem_rdata;
                end else begin
                    mem_we = 1'b1;
                end
            end
            DONE: begin
                if (!strobe) begin
                    state_nx = IDLE;
                    sel_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
                sel_nx   = 1'b0;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op       <= OP_RD;
            wcnt     <= '0;
            offset   <= '0;
            sel      <= 1'b0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_nx;
            op       <= op_nx;
            wcnt     <= wcnt_nx;
            offset   <= offset_nx;
            sel      <= sel_nx;
            ready    <= ready_nx;
            busy     <= busy_nx;
            data_out <= data_out_nx;
        end
    end

endmodule

// File: tb/tb_bus_target_responder.sv
// Randomised and directed bench for bus_target_responder: two instances
// (default window/2 waits, and base 0x80000/0 waits) against a byte-map model.
module tb_bus_target_responder;

    logic             clk;
    logic             rst;
    logic [1:0]       ale_v, rd_v, wr_v;
    logic [1:0][19:0] addr_v;
    logic [1:0][7:0]  din_v;
    logic [1:0][7:0]  dout_v;
    logic [1:0]       rdy_v, busy_v, sel_v;

    int checks;
    int errors;

    logic [7:0] mem_m   [2][256];
    bit         valid_m [2][256];
    logic [7:0] exp_dout  [2];
    bit         dout_known[2];

    bus_target_responder u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .ale      (ale_v[0]),
        .rd       (rd_v[0]),
        .wr       (wr_v[0]),
        .addr_bus (addr_v[0]),
        .data_in  (din_v[0]),
        .data_out (dout_v[0]),
        .ready    (rdy_v[0]),
        .busy     (busy_v[0]),
        .sel      (sel_v[0])
    );

    bus_target_responder #(
        .BASE_ADDR   (20'h80000),
        .ADDR_BITS   (8),
        .WAIT_STATES (0)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .ale      (ale_v[1]),
        .rd       (rd_v[1]),
        .wr       (wr_v[1]),
        .addr_bus (addr_v[1]),
        .data_in  (din_v[1]),
        .data_out (dout_v[1]),
        .ready    (rdy_v[1]),
        .busy     (busy_v[1]),
        .sel      (sel_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic [19:0] base_of(input int d);
        return (d == 0) ? 20'h00000 : 20'h80000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus(input int d);
        ale_v[d] = 1'b0;
        rd_v[d]  = 1'b0;
        wr_v[d]  = 1'b0;
    endtask

    // One complete strobe assertion held for `hold` cycles, then released.
    task automatic txn(input int d, input bit r, input bit w, input bit a_le,
                       input logic [19:0] addr, input logic [7:0] din, input int hold);
        logic [19:0] diff;
        logic [7:0]  off;
        logic [7:0]  dout_at;
        bit          hit;
        int          rdy_cnt, rdy_k, busy_cnt, ws;
        ws       = wait_of(d);
        diff     = addr - base_of(d);
        hit      = a_le && (r || w) && (diff < 20'd256);
        off      = diff[7:0];
        rdy_cnt  = 0;
        rdy_k    = -1;
        busy_cnt = 0;
        dout_at  = '0;
        ale_v[d]  = a_le;
        rd_v[d]   = r;
        wr_v[d]   = w;
        addr_v[d] = addr;
        din_v[d]  = din;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check_eq("accept_busy", 32'(busy_v[d]), 32'(hit));
                check_eq("accept_sel", 32'(sel_v[d]), 32'(hit));
                addr_v[d] = 20'($urandom);
            end
            if (rdy_v[d]) begin
                rdy_cnt++;
                rdy_k   = k;
                dout_at = dout_v[d];
            end
            if (busy_v[d]) busy_cnt++;
            if (k == hold - 1 && hit) check_eq("held_busy", 32'(busy_v[d]), 32'd1);
        end
        check_eq("ready_count", 32'(rdy_cnt), hit ? 32'd1 : 32'd0);
        if (hit) begin
            check_eq("ready_latency", 32'(rdy_k), 32'(ws + 1));
            if (r) begin
                if (valid_m[d][off]) check_eq("read_data", 32'(dout_at), 32'(mem_m[d][off]));
                exp_dout[d]   = mem_m[d][off];
                dout_known[d] = valid_m[d][off];
            end else begin
                if (dout_known[d]) check_eq("wr_dout_hold", 32'(dout_at), 32'(exp_dout[d]));
                mem_m[d][off]   = din;
                valid_m[d][off] = 1'b1;
            end
        end else begin
            check_eq("miss_busy", 32'(busy_cnt), 32'd0);
        end
        idle_bus(d);
        @(negedge clk);
        check_eq("release_busy", 32'(busy_v[d]), 32'd0);
        check_eq("release_sel", 32'(sel_v[d]), 32'd0);
        check_eq("release_ready", 32'(rdy_v[d]), 32'd0);
    endtask

    // Strobes dropped during the first wait cycle of instance 0.
    task automatic abort_txn(input bit r, input bit w, input logic [19:0] addr, input logic [7:0] din);
        int rdy_cnt;
        rdy_cnt   = 0;
        ale_v[0]  = 1'b1;
        rd_v[0]   = r;
        wr_v[0]   = w;
        addr_v[0] = addr;
        din_v[0]  = din;
        @(negedge clk);
        check_eq("abort_accept", 32'(busy_v[0]), 32'd1);
        idle_bus(0);
        @(negedge clk);
        check_eq("abort_busy", 32'(busy_v[0]), 32'd0);
        check_eq("abort_sel", 32'(sel_v[0]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            if (rdy_v[0]) rdy_cnt++;
            @(negedge clk);
        end
        check_eq("abort_ready", 32'(rdy_cnt), 32'd0);
    endtask

    task automatic check_reset_outputs(input int d);
        check_eq("rst_dout", 32'(dout_v[d]), 32'd0);
        check_eq("rst_ready", 32'(rdy_v[d]), 32'd0);
        check_eq("rst_busy", 32'(busy_v[d]), 32'd0);
        check_eq("rst_sel", 32'(sel_v[d]), 32'd0);
    endtask

    initial begin
        int d, ws, hold;
        bit r, w, a_le;
        logic [19:0] addr;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 2; i++) begin
            idle_bus(i);
            addr_v[i]     = '0;
            din_v[i]      = '0;
            exp_dout[i]   = '0;
            dout_known[i] = 1'b1;
            for (int j = 0; j < 256; j++) begin
                mem_m[i][j]   = '0;
                valid_m[i][j] = 1'b0;
            end
        end

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst = 1'b0;
        @(negedge clk);

        // Default window: writes then read-back
        txn(0, 1'b0, 1'b1, 1'b1, 20'h00010, 8'h5A, 5);
        txn(0, 1'b0, 1'b1, 1'b1, 20'h00005, 8'hA5, 5);
        txn(0, 1'b1, 1'b0, 1'b1, 20'h00005, 8'h00, 5);

        // Aborted write and read leave storage untouched
        abort_txn(1'b0, 1'b1, 20'h00010, 8'hEE);
        abort_txn(1'b1, 1'b0, 20'h00005, 8'h00);
        txn(0, 1'b1, 1'b0, 1'b1, 20'h00010, 8'h00, 5);

        // Reset in the middle of a write
        ale_v[0]  = 1'b1;
        wr_v[0]   = 1'b1;
        addr_v[0] = 20'h00010;
        din_v[0]  = 8'h77;
        @(negedge clk);
        check_eq("midop_busy", 32'(busy_v[0]), 32'd1);
        rst = 1'b1;
        idle_bus(0);
        @(negedge clk);
        check_reset_outputs(0);
        rst = 1'b0;
        exp_dout[0]   = '0;
        dout_known[0] = 1'b1;
        exp_dout[1]   = '0;
        dout_known[1] = 1'b1;
        @(negedge clk);
        txn(0, 1'b1, 1'b0, 1'b1, 20'h00010, 8'h00, 5);

        // Zero wait states at a high base, top byte of the window
        txn(1, 1'b0, 1'b1, 1'b1, 20'h800FF, 8'h3C, 3);
        txn(1, 1'b1, 1'b0, 1'b1, 20'h800FF, 8'h00, 3);

        // Misses: outside window, ale low, below base
        txn(0, 1'b1, 1'b0, 1'b1, 20'h00100, 8'h00, 10);
        txn(0, 1'b1, 1'b0, 1'b0, 20'h00005, 8'h00, 10);
        txn(1, 1'b1, 1'b0, 1'b1, 20'h7FFFF, 8'h00, 10);

        // Both strobes high: read wins, storage keeps 0x11
        txn(0, 1'b0, 1'b1, 1'b1, 20'h00005, 8'h11, 5);
        txn(0, 1'b1, 1'b1, 1'b1, 20'h00005, 8'h99, 5);
        txn(0, 1'b1, 1'b0, 1'b1, 20'h00005, 8'h00, 10);

        // Randomised traffic on both instances
        for (int i = 0; i < 80; i++) begin
            d    = int'($urandom_range(0, 1));
            ws   = wait_of(d);
            r    = 1'($urandom);
            w    = 1'($urandom);
            a_le = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) addr = 20'($urandom);
            else                           addr = base_of(d) + 20'($urandom_range(0, 255));
            hold = ws + 3 + int'($urandom_range(0, 4));
            if (d == 0 && (r || w) && a_le && $urandom_range(0, 9) == 0 && addr < 20'd256) begin
                abort_txn(r, w, addr, 8'($urandom));
            end else begin
                txn(d, r, w, a_le, addr, 8'($urandom), hold);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Runaway guard
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
